param_bubblesort: RTL
=====================

PARAM_BUBBLESORT -- requirements
Module: param_bubblesort

Interface
REQ-001 SHALL have parameter WIDTH, default 32, element width in bits.
REQ-002 SHALL have parameter DEPTH, default 5, elements per batch; legal range 2..64.
REQ-003 SHALL have parameter SIGNED, default 1; 1 = two's-complement compare, 0 = unsigned compare.
REQ-004 SHALL have port CLK  input  1  sole clock; all state updates on posedge.
REQ-005 SHALL have port RST_N  input  1  reset, synchronous and active-high despite the name.
REQ-006 SHALL have port put_x  input  WIDTH  element to load.
REQ-007 SHALL have port EN_put  input  1  put strobe.
REQ-008 SHALL have port RDY_put  output  1  put accepted this cycle if EN_put.
REQ-009 SHALL have port mode_descend  input  1  sort order, captured with the first put of a batch.
REQ-010 SHALL have port EN_get  input  1  get strobe.
REQ-011 SHALL have port get  output  WIDTH  current head element.
REQ-012 SHALL have port RDY_get  output  1  get valid and accepted this cycle if EN_get.
REQ-013 SHALL have port count  output  7  elements currently held.

Function
REQ-014 SHALL implement FSM LOAD -> SORT -> DRAIN -> LOAD; no other states.
REQ-015 LOAD: RDY_put=1, RDY_get=0; EN_put writes put_x to slot count and increments count.
REQ-016 First accepted put of a batch (count=0) SHALL latch mode_descend; later changes ignored until next batch.
REQ-017 The put that makes count=DEPTH SHALL move FSM to SORT on the same edge.
REQ-018 SORT SHALL last exactly DEPTH cycles, pass p=0..DEPTH-1, one odd-even transposition pass per cycle.
REQ-019 Even p compares pairs (0,1),(2,3)...; odd p compares pairs (1,2),(3,4)...; all pairs of a pass in parallel.
REQ-020 Swap only if strictly out of order (ascending: slot[i] > slot[i+1]; descending: slot[i] < slot[i+1]); equal elements never swap.
REQ-021 Compare SHALL be signed when SIGNED=1, unsigned when SIGNED=0; no width extension or truncation of stored data.
REQ-022 RDY_put=0 and RDY_get=0 throughout SORT; strobes ignored.
REQ-023 Last put at edge k -> RDY_get=1 in the cycle after edge k+DEPTH.
REQ-024 DRAIN: RDY_get=1, get=slot[0]; EN_get shifts slots down by one and decrements count.
REQ-025 The get that makes count=0 SHALL return FSM to LOAD; RDY_put=1 in the following cycle.
REQ-026 EN_put while RDY_put=0, or EN_get while RDY_get=0, SHALL have no effect.
REQ-027 get SHALL be 0 whenever RDY_get=0.
REQ-028 count SHALL equal DEPTH throughout SORT.

Reset
REQ-029 RST_N=1 at a posedge SHALL force LOAD, count=0, latched mode=ascending, all slots 0, from any state including mid-SORT and mid-DRAIN.
REQ-030 During and after reset: RDY_put=1, RDY_get=0, get=0, count=0; partial batch discarded.

Verification
REQ-031 DEPTH=5, SIGNED=1, ascending: put 1,142,71,173,216 on consecutive cycles -> RDY_get exactly 5 cycles after last put; gets 1,71,142,173,216.
REQ-032 Same data, mode_descend=1 on first put and 0 thereafter -> gets 216,173,142,71,1.
REQ-033 SIGNED=1: put -3,7,0,-128,5 -> gets -128,-3,0,5,7; with SIGNED=0 same bits -> 0,5,7,0xFFFFFF80,0xFFFFFFFD.
REQ-034 Put 4,4,2,2,9 with EN_get held high throughout -> gets 2,2,4,4,9; stray gets before DRAIN ignored; count 5->0 stepwise.
REQ-035 Reset asserted on 3rd SORT cycle -> next cycle RDY_put=1, count=0, get=0; fresh batch 5,4,3,2,1 -> 1,2,3,4,5.
REQ-036 Two batches back-to-back with EN_put and EN_get held high -> second batch's first put accepted the cycle after first batch's last get; both batches sorted correctly.

Source files
------------

// File: rtl/param_bubblesort.sv
// -----------------------------------------------------------------------------
// param_bubblesort
//
// Batch sorter. Loads DEPTH elements, sorts them with an odd-even transposition
// network (one pass per cycle, DEPTH passes), then drains them in sorted order.
// The sort direction is latched from mode_descend on the first put of a batch.
//
// Handshake: a put is accepted on a rising CLK edge exactly when EN_put=1 and
// RDY_put=1 in the cycle before that edge. A get is accepted the same way when
// EN_get=1 and RDY_get=1. A strobe seen while its ready is low is ignored and
// has no side effects. get carries the head element only while RDY_get=1 and
// is 0 otherwise.
//
// Ports:
//   CLK          in   1      sole clock, all state updates on posedge
//   RST_N        in   1      synchronous reset, active HIGH despite the name
//   put_x        in   WIDTH  element to load
//   EN_put       in   1      put strobe
//   RDY_put      out  1      put is accepted this cycle if EN_put
//   mode_descend in   1      sort order, captured on the first put of a batch
//   EN_get       in   1      get strobe
//   get          out  WIDTH  current head element (0 when RDY_get=0)
//   RDY_get      out  1      get is valid and accepted this cycle if EN_get
//   count        out  7      number of elements currently held
//   o_dbg_state  out  2      FSM state: 0=LOAD, 1=SORT, 2=DRAIN
// -----------------------------------------------------------------------------
module param_bubblesort #(
    parameter int WIDTH  = 32,
    parameter int DEPTH  = 5,
    parameter int SIGNED = 1
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [WIDTH-1:0] put_x,
    input  logic             EN_put,
    output logic             RDY_put,
    input  logic             mode_descend,
    input  logic             EN_get,
    output logic [WIDTH-1:0] get,
    output logic             RDY_get,
    output logic [6:0]       count,
    output logic [1:0]       o_dbg_state
);

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_SORT  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    // Pass counter only has to reach DEPTH-1.
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    state_t           r_state;
    state_t           w_next_state;
    logic [WIDTH-1:0] r_slot [DEPTH];
    logic [WIDTH-1:0] w_sorted [DEPTH];
    logic [6:0]       r_count;
    logic             r_desc;
    logic [PW-1:0]    r_pass;
    logic             w_put_fire;
    logic             w_get_fire;
    logic             w_last_pass;

    // True when the pair (a, b) sitting in slots (i, i+1) must be exchanged.
    // Equal elements never swap, which keeps the sort stable for ties.
    function automatic logic out_of_order(input logic [WIDTH-1:0] a,
                                          input logic [WIDTH-1:0] b,
                                          input logic             desc);
        logic res;
        if (SIGNED != 0) begin
            res = desc ? ($signed(b) > $signed(a)) : ($signed(a) > $signed(b));
        end else begin
            res = desc ? (b > a) : (a > b);
        end
        return res;
    endfunction

    assign w_put_fire  = EN_put && (r_state == ST_LOAD) && !RST_N;
    assign w_get_fire  = EN_get && (r_state == ST_DRAIN) && !RST_N;
    assign w_last_pass = (r_pass == PW'(DEPTH - 1));

    // Next-state and handshake outputs.
    always_comb begin
        w_next_state = r_state;
        RDY_put      = 1'b0;
        RDY_get      = 1'b0;
        get          = '0;
        case (r_state)
            ST_LOAD: begin
                RDY_put = 1'b1;
                if (EN_put && (r_count == 7'(DEPTH - 1))) begin
                    w_next_state = ST_SORT;
                end
            end
            ST_SORT: begin
                if (w_last_pass) begin
                    w_next_state = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                RDY_get = 1'b1;
                get     = r_slot[0];
                if (EN_get && (r_count == 7'd1)) begin
                    w_next_state = ST_LOAD;
                end
            end
            default: begin
                w_next_state = ST_LOAD;
            end
        endcase
        // Reset overrides the outputs in the reset cycle itself, so the
        // visible interface already looks like an empty LOAD state.
        if (RST_N) begin
            w_next_state = ST_LOAD;
            RDY_put      = 1'b1;
            RDY_get      = 1'b0;
            get          = '0;
        end
    end

    // One odd-even transposition pass. Even passes pair (0,1),(2,3)...,
    // odd passes pair (1,2),(3,4)...; the pairs of a pass are disjoint, so
    // all of them read the registered slots and update in parallel.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            w_sorted[i] = r_slot[i];
        end
        for (int i = 0; i < DEPTH - 1; i++) begin
            if (((i % 2) == 1) == r_pass[0]) begin
                if (out_of_order(r_slot[i], r_slot[i+1], r_desc)) begin
                    w_sorted[i]   = r_slot[i+1];
                    w_sorted[i+1] = r_slot[i];
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST_N) begin
            r_state <= ST_LOAD;
            r_count <= '0;
            r_desc  <= 1'b0;
            r_pass  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_slot[i] <= '0;
            end
        end else begin
            r_state <= w_next_state;
            case (r_state)
                ST_LOAD: begin
                    r_pass <= '0;
                    if (w_put_fire) begin
                        for (int i = 0; i < DEPTH; i++) begin
                            if (r_count == 7'(i)) begin
                                r_slot[i] <= put_x;
                            end
                        end
                        if (r_count == 7'd0) begin
                            r_desc <= mode_descend;
                        end
                        r_count <= r_count + 7'd1;
                    end
                end
                ST_SORT: begin
                    for (int i = 0; i < DEPTH; i++) begin
                        r_slot[i] <= w_sorted[i];
                    end
                    r_pass <= w_last_pass ? '0 : r_pass + PW'(1);
                end
                ST_DRAIN: begin
                    if (w_get_fire) begin
                        for (int i = 0; i < DEPTH - 1; i++) begin
                            r_slot[i] <= r_slot[i+1];
                        end
                        r_slot[DEPTH-1] <= '0;
                        r_count         <= r_count - 7'd1;
                    end
                end
                default: begin
                    r_count <= '0;
                end
            endcase
        end
    end

    assign count       = r_count;
    assign o_dbg_state = r_state;

endmodule
